// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, flagging the first bit of each word.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_adv;

  // The word sits in shreg aligned so that the bit now on sout is at the
  // leading end; advancing shifts the next bit into that position.
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign next_bit  = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
  assign shreg_adv = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  assign din_ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = 1'b0;
    if (accept) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      shreg_d       = din;
      sout_d        = first_bit;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shreg_adv;
            sout_d  = next_bit;
          end else begin
            state_d      = IDLE;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a queue model of the serial line.
module tb_piso_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic rdy_m, sout_m, sv_m, fs_m, busy_m;
  logic rdy_l, sout_l, sv_l, fs_l, busy_l;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic b;
    logic first;
  } item_t;

  // Bits still to appear on each line, head = bit currently on sout.
  item_t line_m[$];
  item_t line_l[$];

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m),
    .frame_start(fs_m), .busy(busy_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l),
    .frame_start(fs_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic e_v_m, e_b_m, e_f_m, e_v_l, e_b_l, e_f_l;
    e_v_m = (line_m.size() > 0);
    e_b_m = e_v_m ? line_m[0].b : 1'b0;
    e_f_m = e_v_m ? line_m[0].first : 1'b0;
    e_v_l = (line_l.size() > 0);
    e_b_l = e_v_l ? line_l[0].b : 1'b0;
    e_f_l = e_v_l ? line_l[0].first : 1'b0;
    check_eq("msb_ready", 32'(rdy_m), 32'(line_m.size() <= 1));
    check_eq("msb_sout", 32'(sout_m), 32'(e_b_m));
    check_eq("msb_valid", 32'(sv_m), 32'(e_v_m));
    check_eq("msb_frame", 32'(fs_m), 32'(e_f_m));
    check_eq("msb_busy", 32'(busy_m), 32'(e_v_m));
    check_eq("lsb_ready", 32'(rdy_l), 32'(line_l.size() <= 1));
    check_eq("lsb_sout", 32'(sout_l), 32'(e_b_l));
    check_eq("lsb_valid", 32'(sv_l), 32'(e_v_l));
    check_eq("lsb_frame", 32'(fs_l), 32'(e_f_l));
    check_eq("lsb_busy", 32'(busy_l), 32'(e_v_l));
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic cycle(output logic acc);
    logic [W-1:0] word;
    @(negedge clk);
    check_outputs();
    acc  = din_valid && rst && (line_m.size() <= 1);
    word = din;
    @(posedge clk);
    if (rst) begin
      if (line_m.size() > 0) void'(line_m.pop_front());
      if (line_l.size() > 0) void'(line_l.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          line_m.push_back('{b: word[W-1-i], first: (i == 0)});
          line_l.push_back('{b: word[i], first: (i == 0)});
        end
        $display("accept word %b at %0t", word, $time);
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    logic acc;
    #3 rst = 1'b0;
    run(3);
    rst = 1'b1;

    // Idle line after reset
    run(10);

    // Single word 1010
    din = 4'b1010; din_valid = 1'b1;
    cycle(acc);
    check_eq("accept_1010", 32'(acc), 32'd1);
    din_valid = 1'b0;
    run(6);

    // Back-to-back 1111 then 1100 accepted on the last-bit edge
    din = 4'b1111; din_valid = 1'b1;
    cycle(acc);
    din = 4'b1100;
    run(4);
    din_valid = 1'b0;
    run(6);

    // Hold-off: 0110 offered while 1010 is mid-word must be ignored
    din = 4'b1010; din_valid = 1'b1;
    cycle(acc);
    din = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      cycle(acc);
      check_eq("holdoff_no_accept", 32'(acc), 32'd0);
    end
    din_valid = 1'b0;
    run(5);

    // Reset while the second bit of 1010 is on the line
    din = 4'b1010; din_valid = 1'b1;
    cycle(acc);
    din_valid = 1'b0;
    cycle(acc);
    #2 rst = 1'b0;
    #1;
    check_eq("async_sout", 32'(sout_m | sout_l), 32'd0);
    check_eq("async_valid", 32'(sv_m | sv_l), 32'd0);
    check_eq("async_frame", 32'(fs_m | fs_l), 32'd0);
    check_eq("async_busy", 32'(busy_m | busy_l), 32'd0);
    line_m.delete();
    line_l.delete();
    run(2);
    rst = 1'b1;
    run(5);

    // 1100: LSB-first instance sends 0,0,1,1
    din = 4'b1100; din_valid = 1'b1;
    cycle(acc);
    din_valid = 1'b0;
    run(6);

    // Random traffic; producer holds each word until it is accepted
    acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!din_valid || acc) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din       = W'($urandom);
      end
      cycle(acc);
    end
    din_valid = 1'b0;
    run(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with a frame marker.
- Serialising counterpart to the team's parallel/serial register blocks. Feeds a serial link whose far end is a SIPO receiver.
- Supports back-to-back words with zero idle cycles between frames.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept din on this edge (combinational).
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a valid bit (registered).
- frame_start  output  1  high on the first bit of each word (registered).
- busy  output  1  high while a word is being shifted (state == SHIFT).

Behaviour:
- Reset: rst low asynchronously forces these values immediately, regardless of clk:
  - state IDLE;
  - sout = 0, sout_valid = 0, frame_start = 0, busy = 0;
  - shift register = 0, bit counter cnt = 0.
  - Any word in flight is discarded; after rst releases there is no partial resume.
- State machine: two states, IDLE and SHIFT.
- din_ready = (state == IDLE) OR (state == SHIFT AND cnt == WIDTH-1). It does not depend on din_valid.
- Accept: rising edge with din_valid & din_ready. On that edge:
  - latch din into the shift register;
  - sout <= first bit (din[WIDTH-1] if MSB_FIRST, else din[0]);
  - sout_valid <= 1, frame_start <= 1;
  - cnt <= 0, state <= SHIFT.
- SHIFT with cnt < WIDTH-1: on each edge, cnt <= cnt+1, sout <= next bit in the selected order, frame_start <= 0, sout_valid stays 1.
- SHIFT with cnt == WIDTH-1 (last bit on sout):
  - with accept on that edge: the new word loads per the accept rule, so the stream is continuous and frame_start is high on the new word's first bit;
  - without accept: state <= IDLE, sout_valid <= 0, sout <= 0, frame_start <= 0.
- Latency:
  - the first bit appears on sout in the cycle after the accept edge;
  - each word occupies exactly WIDTH consecutive sout_valid cycles.
- din_valid while din_ready is low is ignored. The producer holds the word until it is accepted; din is sampled only on the accept edge.
- din changing after the accept edge has no effect on the word in flight.
- Counter: cnt is $clog2(WIDTH) bits wide. It never wraps past WIDTH-1; it reloads to 0 only on accept.
- In IDLE, sout is held at 0; sout_valid = 0 means the line is idle.
- sout_valid = 1 and frame_start = 1 occur together only on the first bit of a word.

Test Plan:
- WIDTH=4, MSB_FIRST=1; release rst; din=1010, din_valid for one accept cycle:
  - required: sout = 1,0,1,0 on the 4 cycles after accept, sout_valid = 1 for exactly those 4 cycles;
  - frame_start only on the first of them; busy = 1 for 4 cycles; then sout = 0, sout_valid = 0.
- Back-to-back: din=1111 accepted, din_valid held with din=1100 so it is accepted on the last-bit edge:
  - required: 8 contiguous valid bits 1,1,1,1,1,1,0,0 with no gap;
  - frame_start on bits 1 and 5; din_ready high only in IDLE and on each cnt==3 cycle.
- Hold-off: after 1010 is accepted, pulse din_valid with din=0110 during bits 1–3:
  - required: din_ready = 0 during those bits, 0110 is not accepted, and the output is unchanged (1,0,1,0).
- Reset mid-word: pull rst low while the second bit of 1010 is on sout:
  - required: sout, sout_valid, busy and frame_start go to 0 immediately, without waiting for clk;
  - after release with din_valid low, the line stays idle.
- MSB_FIRST=0; din=1100 accepted:
  - required: sout = 0,0,1,1, with frame_start on the first bit.
- Idle after reset with din_valid = 0 for 10 cycles:
  - required: din_ready = 1, sout_valid = 0, sout = 0, busy = 0 throughout.
